mux: RTL and testbench
======================

# mux

Parameterisable 4:1 selector used in the Viterbi datapath to pick one of four candidate bits/words (e.g. survivor bits or branch decisions) from a two-bit select formed by `d1` (MSB) and `d0` (LSB). It provides a purely combinational output plus a clocked copy for pipelined consumers. It has no internal state beyond the optional output register.

## Interface
Parameters:
- `WIDTH`, default 1, width of each data input and of both outputs.

Ports:
- `clk`  input  1  single clock; rising edge active.
- `rst_n`  input  1  reset; synchronous and active-low.
- `in0`  input  WIDTH  candidate selected when {d1,d0} = 2'b00.
- `in1`  input  WIDTH  candidate selected when {d1,d0} = 2'b01.
- `in2`  input  WIDTH  candidate selected when {d1,d0} = 2'b10.
- `in3`  input  WIDTH  candidate selected when {d1,d0} = 2'b11.
- `d0`  input  1  select LSB.
- `d1`  input  1  select MSB.
- `out`  output  WIDTH  combinational selected value.
- `out_q`  output  WIDTH  registered (or bypassed) selected value; see Configuration.

## Operation
- sel = {d1, d0}; out = in0/in1/in2/in3 for sel = 0/1/2/3.
- `out` is combinational: updates in the same delta as any input/select change, independent of `clk` and `rst_n`.
- Each data input is routed to the output unmodified; no inversion, no arithmetic.
- X/Z on a select bit: `out` is X (no priority defaulting); synthesis must not infer latches.
- `rst_n` has no effect on `out`.
- WIDTH applies uniformly; all bits of the selected input pass in parallel.

## Timing
- `out`: zero-cycle latency (combinational path from inX, d0, d1).
- `out_q` with register enabled: captures `out` on each rising `clk`; latency 1 cycle.
- Reset: when `rst_n` = 0 at a rising edge, `out_q` <= 0 (all WIDTH bits); takes priority over capture. Reset asserted mid-operation clears `out_q` at the next edge; first capture after release occurs on the first rising edge with `rst_n` = 1.
- Select and data changing in the same cycle: `out_q` reflects the values present at the sampling edge only; no glitch filtering.
- Before the first clock edge, `out_q` is undefined (register build) or equals `out` (bypass build).

## Configuration
- Macro `MUX_OUT_REG_EN`.
- Defined: `out_q` is a WIDTH-bit flop loaded with `out` every rising `clk`, synchronously cleared to 0 by `rst_n` = 0; 1-cycle latency.
- Not defined: `out_q` is a continuous copy of `out` (zero latency); `clk` and `rst_n` are unused and no flops are built.
- `out` behaviour is identical in both builds.

## Test plan
- Walking zero at in0: in0..in3 = 0,1,1,1; sweep {d1,d0} = 00,01,10,11 every 50 ns -> out = 0,1,1,1.
- Walking zero at in1: in = 1,0,1,1; same sweep -> out = 1,0,1,1; repeat for in2 (1,1,0,1) and in3 (1,1,1,0) -> zero appears only at sel 2 and 3 respectively.
- All inputs 0, sel = 00 at start -> out = 0; all inputs 1 with every sel -> out = 1.
- `MUX_OUT_REG_EN` defined, WIDTH = 1: rst_n = 0 for 2 edges -> out_q = 0; release, in3 = 1, sel = 11 -> out_q = 1 exactly one edge later while out = 1 immediately.
- Reset mid-run (register build): out_q = 1, drive rst_n = 0 for one edge -> out_q = 0 at that edge though out stays 1; release -> out_q = 1 next edge.
- WIDTH = 8: in0..in3 = 8'hA5, 8'h5A, 8'hFF, 8'h00; sweep sel -> out = A5, 5A, FF, 00.

Source files
------------

// File: rtl/mux.sv
// mux: parameterisable 4:1 selector for the Viterbi datapath.
// Picks one of four WIDTH-bit candidates using the select {d1, d0}.
// Provides a combinational output 'out' and a copy 'out_q' for pipelined consumers.
// Build option MUX_OUT_REG_EN:
//   defined   -> out_q is a 1-cycle register with synchronous active-low clear.
//   undefined -> out_q is a continuous copy of out, and no flops are built.
module mux #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             d0,
  input  logic             d1,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [1:0] sel;

  assign sel = {d1, d0};

  // Combinational selection.
  // An unknown select drives X rather than defaulting to one of the inputs.
  always_comb begin
    out = 'x;
    case (sel)
      2'b00:   out = in0;
      2'b01:   out = in1;
      2'b10:   out = in2;
      2'b11:   out = in3;
      default: out = 'x;
    endcase
  end

`ifdef MUX_OUT_REG_EN
  // Pipelined copy of the selection. Reset takes priority over capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end
`else
  // Bypass: out_q follows out with no latency.
  // clk and rst_n are intentionally left without a load in this build.
  assign out_q = out;

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_mux.sv
// tb_mux: randomized self-checking bench for mux, covering WIDTH=1 and WIDTH=8.
// The reference model picks a candidate from an array indexed by the select.
// Build option MUX_OUT_REG_EN selects the expected out_q behaviour.
module tb_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] a0, a1, a2, a3, aout, aout_q;
  logic       ad0, ad1;
  logic [7:0] b0, b1, b2, b3, bout, bout_q;
  logic       bd0, bd1;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic       q_valid = 1'b0;
  logic [0:0] exp_aq;
  logic [7:0] exp_bq;

  always #5 clk = ~clk;

  mux #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in0(a0), .in1(a1), .in2(a2), .in3(a3),
    .d0(ad0), .d1(ad1),
    .out(aout), .out_q(aout_q)
  );

  mux #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in0(b0), .in1(b1), .in2(b2), .in3(b3),
    .d0(bd0), .d1(bd1),
    .out(bout), .out_q(bout_q)
  );

  // Reference selection: index an array of the four candidates by the select.
  function automatic logic [7:0] pick(input logic [7:0] c0, input logic [7:0] c1,
                                      input logic [7:0] c2, input logic [7:0] c3,
                                      input logic [1:0] s);
    logic [7:0] cand [4];
    cand = '{c0, c1, c2, c3};
    return cand[s];
  endfunction

  function automatic logic [0:0] ref1();
    logic [7:0] r;
    r = pick({7'd0, a0}, {7'd0, a1}, {7'd0, a2}, {7'd0, a3}, {ad1, ad0});
    return r[0:0];
  endfunction

  function automatic logic [7:0] ref8();
    return pick(b0, b1, b2, b3, {bd1, bd0});
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered-output expectation: each edge samples the model, or clears to zero under reset.
  always @(posedge clk) begin
    exp_aq  <= rst_n ? ref1() : 1'b0;
    exp_bq  <= rst_n ? ref8() : 8'h00;
    q_valid <= 1'b1;
  end

  // Every-cycle comparison against the model, made away from the active edge.
  always @(negedge clk) begin
    if (q_valid) begin
      check("out_w1", {7'd0, aout}, {7'd0, ref1()});
      check("out_w8", bout, ref8());
`ifdef MUX_OUT_REG_EN
      check("out_q_w1", {7'd0, aout_q}, {7'd0, exp_aq});
      check("out_q_w8", bout_q, exp_bq);
`else
      check("out_q_w1", {7'd0, aout_q}, {7'd0, ref1()});
      check("out_q_w8", bout_q, ref8());
`endif
    end
  end

  task automatic set1(input logic [3:0] v, input logic [1:0] s);
    a0 = v[3]; a1 = v[2]; a2 = v[1]; a3 = v[0];
    {ad1, ad0} = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] want;
    logic [7:0] want8 [4];

    // All inputs 0, select 00, reset held low for two edges.
    rst_n = 1'b0;
    set1(4'b0000, 2'b00);
    b0 = 8'h00; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00; {bd1, bd0} = 2'b00;
    step();
    step();
    @(negedge clk);
    check("start_out", {7'd0, aout}, 8'h00);
    check("reset_out_q", {7'd0, aout_q}, 8'h00);
    check("reset_out_q_w8", bout_q, 8'h00);

    // Release reset, select in3 = 1: out changes at once, out_q follows one edge later.
    step();
    rst_n = 1'b1;
    set1(4'b0001, 2'b11);
    @(negedge clk);
    check("sel3_out_now", {7'd0, aout}, 8'h01);
`ifdef MUX_OUT_REG_EN
    check("sel3_out_q_before_edge", {7'd0, aout_q}, 8'h00);
`else
    check("sel3_out_q_bypass", {7'd0, aout_q}, 8'h01);
`endif
    step();
    @(negedge clk);
    check("sel3_out_q_after_edge", {7'd0, aout_q}, 8'h01);

    // Reset asserted mid-run: out_q clears while out stays 1, then recovers.
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("midreset_out", {7'd0, aout}, 8'h01);
`ifdef MUX_OUT_REG_EN
    check("midreset_out_q", {7'd0, aout_q}, 8'h00);
`else
    check("midreset_out_q", {7'd0, aout_q}, 8'h01);
`endif
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("postreset_out_q", {7'd0, aout_q}, 8'h01);

    // Walking zero across in0..in3 with a select sweep. All-ones pattern last.
    for (int p = 0; p < 5; p++) begin
      pat = (p < 4) ? ~(4'b1000 >> p) : 4'b1111;
      for (int s = 0; s < 4; s++) begin
        step();
        set1(pat, 2'(s));
        @(negedge clk);
        want = pat;
        check($sformatf("walk%0d_sel%0d", p, s), {7'd0, aout}, {7'd0, want[3 - s]});
      end
    end

    // WIDTH=8 sweep.
    want8 = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    for (int s = 0; s < 4; s++) begin
      step();
      b0 = 8'hA5; b1 = 8'h5A; b2 = 8'hFF; b3 = 8'h00;
      {bd1, bd0} = 2'(s);
      @(negedge clk);
      check($sformatf("w8_sel%0d", s), bout, want8[s]);
    end

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 2000; i++) begin
      step();
      rst_n = ($urandom_range(15) != 0);
      a0 = 1'($urandom); a1 = 1'($urandom); a2 = 1'($urandom); a3 = 1'($urandom);
      ad0 = 1'($urandom); ad1 = 1'($urandom);
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      bd0 = 1'($urandom); bd1 = 1'($urandom);
    end

    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
